// File: rtl/imm_encoder.sv
// Immediate encoder: builds RV64 I/B words and LI (ADDI or LUI+ADDIW)
// sequences from signed immediates, one word per cycle on a valid/ready stream.
module imm_encoder #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [2:0]      req_funct3,
  input  logic [4:0]      req_rd,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic            out_last,
  output logic            err
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state, state_nx;
  logic [31:0] pend_q;
  logic        accept, consume;
  logic        sx11, sx12, sx31;
  logic        legal, two, last1;
  logic [31:0] w1;
  logic [19:0] hi;
  logic [31:0] i_word, b_word;
  logic [31:0] addi_word, lui_word, addiw_word;

  assign req_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = req_valid && req_ready;
  assign consume   = out_valid && out_ready;

  assign sx11 = (&req_imm[63:11]) | ~(|req_imm[63:11]);
  assign sx12 = (&req_imm[63:12]) | ~(|req_imm[63:12]);
  assign sx31 = (&req_imm[63:31]) | ~(|req_imm[63:31]);

  // Rounding up by imm[11] compensates for ADDIW sign-extending lo.
  assign hi = req_imm[31:12] + {19'd0, req_imm[11]};

  assign i_word = {req_imm[11:0], req_rs1, req_funct3,
                   req_rd, 7'b0010011};
  assign b_word = {req_imm[12], req_imm[10:5], req_rs2,
                   req_rs1, req_funct3, req_imm[4:1],
                   req_imm[11], 7'b1100011};
  assign addi_word  = {req_imm[11:0], 5'd0, 3'b000,
                       req_rd, 7'b0010011};
  assign lui_word   = {hi, req_rd, 7'b0110111};
  assign addiw_word = {req_imm[11:0], req_rd, 3'b000,
                       req_rd, 7'b0011011};

  always_comb begin
    legal = 1'b0;
    two   = 1'b0;
    last1 = 1'b1;
    w1    = '0;
    unique case (req_kind)
      2'd0: begin
        legal = sx11;
        w1    = i_word;
      end
      2'd1: begin
        legal = sx12 & ~req_imm[0];
        w1    = b_word;
      end
      2'd2: begin
        legal = sx31;
        if (sx11) begin
          w1 = addi_word;
        end else begin
          w1    = lui_word;
          two   = |req_imm[11:0];
          last1 = ~two;
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && legal && two) state_nx = PEND;
      PEND:    if (consume) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      pend_q    <= '0;
    end else begin
      err <= accept && !legal;
      if (accept) begin
        out_valid <= legal;
        if (legal) begin
          out_instr <= w1;
          out_last  <= last1;
          pend_q    <= addiw_word;
        end
      end else if (consume) begin
        if (state == PEND) begin
          out_instr <= pend_q;
          out_last  <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: directed spec vectors plus randomized
// requests checked against an arithmetic reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [63:0] req_imm;
  logic        out_valid, out_ready, out_last, err;
  logic [31:0] out_instr;
  logic [34:0] obs;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign obs = {out_valid, out_last, err, out_instr};

  imm_encoder #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last), .err(err)
  );

  // Reference: legality from signed ranges, words from field arithmetic.
  function automatic void model(
    input  logic [1:0]  k,
    input  logic [2:0]  f3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output bit          ok,
    output int          n,
    output logic [31:0] w1,
    output logic [31:0] w2,
    output bit          l1
  );
    longint      s;
    logic [31:0] lo, hi, u;
    s  = longint'(imm);
    lo = {20'd0, imm[11:0]};
    ok = 0; n = 0; w1 = '0; w2 = '0; l1 = 1;
    case (k)
      2'd0: if (s >= -2048 && s <= 2047) begin
        ok = 1; n = 1;
        w1 = (lo << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
           | (32'(rd) << 7) | 32'h13;
      end
      2'd1: if (s >= -4096 && s <= 4094 && (s % 2) == 0) begin
        ok = 1; n = 1;
        w1 = (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25)
           | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
           | (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7) | 32'h63;
      end
      2'd2: if (s >= -64'sh80000000 && s <= 64'sh7FFFFFFF) begin
        ok = 1;
        if (s >= -2048 && s <= 2047) begin
          n  = 1;
          w1 = (lo << 20) | (32'(rd) << 7) | 32'h13;
        end else begin
          u  = imm[31:0];
          hi = (u + 32'h800) >> 12;
          w1 = (hi << 12) | (32'(rd) << 7) | 32'h37;
          if (lo == 0) n = 1;
          else begin
            n = 2; l1 = 0;
            w2 = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h1B;
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(
    input  logic [1:0]  k,
    input  logic [2:0]  f3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic        rdy
  );
    @(negedge clk);
    req_valid = 1; req_kind = k; req_funct3 = f3;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; out_ready = 1;
    req_kind = 0; req_funct3 = 0; req_rd = 0;
    req_rs1 = 0; req_rs2 = 0; req_imm = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 35'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp %h", obs, 35'h0);
    end
    reset = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_itype();
    logic rdy;
    out_ready = 1;
    issue(0, 0, 5, 6, 0, 64'hFFFF_FFFF_FFFF_FFFF, rdy);
    checks++;
    if (rdy !== 1'b1 || obs !== {3'b110, 32'hFFF30293}) begin
      fails++;
      $display("FAIL i_neg1 got %b %h exp 1 %h", rdy, obs, {3'b110, 32'hFFF30293});
    end
    issue(0, 0, 5, 6, 0, 64'd2047, rdy);
    checks++;
    if (obs !== {3'b110, 32'h7FF30293}) begin
      fails++;
      $display("FAIL i_2047 got %h exp %h", obs, {3'b110, 32'h7FF30293});
    end
    issue(0, 0, 5, 6, 0, 64'd2048, rdy);
    checks++;
    if ({out_valid, err} !== 2'b01) begin
      fails++;
      $display("FAIL i_2048_err got v=%b e=%b exp v=0 e=1", out_valid, err);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, err} !== 2'b00) begin
      fails++;
      $display("FAIL i_err_pulse got v=%b e=%b exp v=0 e=0", out_valid, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_btype();
    logic rdy;
    out_ready = 1;
    issue(1, 0, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFC, rdy);
    checks++;
    if (obs !== {3'b110, 32'hFE208EE3}) begin
      fails++;
      $display("FAIL b_neg4 got %h exp %h", obs, {3'b110, 32'hFE208EE3});
    end
    issue(1, 0, 0, 1, 2, 64'd3, rdy);
    checks++;
    if ({out_valid, err} !== 2'b01) begin
      fails++;
      $display("FAIL b_odd_err got v=%b e=%b exp v=0 e=1", out_valid, err);
    end
    issue(1, 0, 0, 1, 2, 64'd4096, rdy);
    checks++;
    if ({out_valid, err} !== 2'b01) begin
      fails++;
      $display("FAIL b_4096_err got v=%b e=%b exp v=0 e=1", out_valid, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_li();
    logic rdy;
    out_ready = 1;
    issue(2, 0, 3, 0, 0, 64'd5, rdy);
    checks++;
    if (obs !== {3'b110, 32'h00500193}) begin
      fails++;
      $display("FAIL li_5 got %h exp %h", obs, {3'b110, 32'h00500193});
    end
    issue(2, 0, 10, 0, 0, 64'h12345678, rdy);
    checks++;
    if (obs !== {3'b100, 32'h12345537} || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL li_lui got %h rdy=%b exp %h rdy=0", obs, req_ready, {3'b100, 32'h12345537});
    end
    @(negedge clk);
    checks++;
    if (obs !== {3'b110, 32'h6785051B}) begin
      fails++;
      $display("FAIL li_addiw got %h exp %h", obs, {3'b110, 32'h6785051B});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL li_done got v=%b exp 0", out_valid);
    end
    issue(2, 0, 1, 0, 0, 64'h7FFFFFFF, rdy);
    checks++;
    if (obs !== {3'b100, 32'h800000B7}) begin
      fails++;
      $display("FAIL li_max_lui got %h exp %h", obs, {3'b100, 32'h800000B7});
    end
    @(negedge clk);
    checks++;
    if (obs !== {3'b110, 32'hFFF0809B}) begin
      fails++;
      $display("FAIL li_max_addiw got %h exp %h", obs, {3'b110, 32'hFFF0809B});
    end
    issue(2, 0, 1, 0, 0, 64'h1_0000_0000, rdy);
    checks++;
    if ({out_valid, err} !== 2'b01) begin
      fails++;
      $display("FAIL li_range_err got v=%b e=%b exp v=0 e=1", out_valid, err);
    end
    issue(2, 0, 1, 0, 0, 64'h12345000, rdy);
    checks++;
    if (obs !== {3'b110, 32'h123450B7}) begin
      fails++;
      $display("FAIL li_lo0 got %h exp %h", obs, {3'b110, 32'h123450B7});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL li_lo0_single got v=%b exp 0", out_valid);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic rdy;
    out_ready = 0;
    issue(2, 0, 10, 0, 0, 64'h12345678, rdy);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== {3'b100, 32'h12345537} || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d got %h rdy=%b exp %h rdy=0", i, obs, req_ready, {3'b100, 32'h12345537});
      end
      if (i < 4) @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== {3'b110, 32'h6785051B}) begin
      fails++;
      $display("FAIL bp_word2 got %h exp %h", obs, {3'b110, 32'h6785051B});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [8];
    logic [31:0] w2;
    logic [63:0] imm;
    logic [4:0]  rd, rs1;
    logic [2:0]  f3;
    bit          ok, l1;
    int          n;
    out_ready = 1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (obs !== {3'b110, exp_w[i-1]}) begin
          fails++;
          $display("FAIL b2b_%0d got %h exp %h", i - 1, obs, {3'b110, exp_w[i-1]});
        end
      end
      if (i < 8) begin
        rd = 5'($urandom); rs1 = 5'($urandom); f3 = 3'($urandom);
        imm = 64'(longint'($urandom_range(0, 4095)) - 2048);
        model(2'd0, f3, rd, rs1, 5'd0, imm, ok, n, exp_w[i], w2, l1);
        req_valid = 1; req_kind = 0; req_funct3 = f3;
        req_rd = rd; req_rs1 = rs1; req_rs2 = 0; req_imm = imm;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_ready%0d got %b exp 1", i, req_ready);
        end
      end else begin
        req_valid = 0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_pend();
    logic rdy;
    out_ready = 0;
    issue(2, 0, 10, 0, 0, 64'h12345678, rdy);
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if (obs !== 35'h0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_pend got %h rdy=%b exp %h rdy=1", obs, req_ready, 35'h0);
    end
    out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_no_addiw got v=%b exp 0", out_valid);
      end
    end
    issue(0, 0, 5, 6, 0, 64'hFFFF_FFFF_FFFF_FFFF, rdy);
    checks++;
    if (obs !== {3'b110, 32'hFFF30293}) begin
      fails++;
      $display("FAIL rst_post got %h exp %h", obs, {3'b110, 32'hFFF30293});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] imm;
    logic [31:0] r, w1, w2;
    logic [1:0]  k;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        rdy;
    longint      s;
    bit          ok, l1;
    int          n;
    out_ready = 1;
    for (int i = 0; i < 60; i++) begin
      k = 2'($urandom_range(0, 3));
      f3 = 3'($urandom); rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      r = $urandom;
      case ($urandom_range(0, 4))
        0: begin
          s = longint'($urandom_range(0, 8191)) - 4096;
          imm = 64'(s);
        end
        1: imm = {{32{r[31]}}, r};
        2: imm = {$urandom, $urandom};
        3: imm = {{32{r[31]}}, r[31:12], 12'd0};
        default: begin
          s = longint'($urandom_range(0, 16)) + 2040;
          imm = ($urandom_range(0, 1) != 0) ? 64'(s) : 64'(-s);
        end
      endcase
      model(k, f3, rd, rs1, rs2, imm, ok, n, w1, w2, l1);
      issue(k, f3, rd, rs1, rs2, imm, rdy);
      checks++;
      if (rdy !== 1'b1) begin
        fails++;
        $display("FAIL rnd_ready%0d got %b exp 1", i, rdy);
      end
      if (!ok) begin
        checks++;
        if ({out_valid, err} !== 2'b01) begin
          fails++;
          $display("FAIL rnd_err%0d k=%0d imm=%h got v=%b e=%b exp v=0 e=1", i, k, imm, out_valid, err);
        end
      end else begin
        checks++;
        if (obs !== {1'b1, l1, 1'b0, w1}) begin
          fails++;
          $display("FAIL rnd_w1_%0d k=%0d imm=%h got %h exp %h", i, k, imm, obs, {1'b1, l1, 1'b0, w1});
        end
        if (n == 2) begin
          @(negedge clk);
          checks++;
          if (obs !== {3'b110, w2}) begin
            fails++;
            $display("FAIL rnd_w2_%0d imm=%h got %h exp %h", i, imm, obs, {3'b110, w2});
          end
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_itype();
    test_btype();
    test_li();
    test_backpressure();
    test_back_to_back();
    test_reset_pend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
